mult_seq_ctrl: RTL and testbench

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential shift-and-add unsigned multiplier.
// One operand pair is accepted from IDLE. N RUN cycles then retire one
// multiplier bit per clock. The product is published on the RUN-to-DONE edge.
module mult_seq_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [N-1:0]   mcand_r;
  logic [N-1:0]   p_hi_r;
  logic [N-1:0]   p_lo_r;
  logic [CW-1:0]  cnt_r;

  logic           load_s;
  logic           run_s;
  logic           last_s;
  logic [N:0]     sum_s;
  logic [N-1:0]   next_hi_s;
  logic [N-1:0]   next_lo_s;

  // Shift-add step: conditional add of the multiplicand into the high half,
  // then shift the whole work register right with the carry entering the MSB.
  always_comb begin
    load_s    = 1'b0;
    run_s     = 1'b0;
    last_s    = 1'b0;
    sum_s     = {(N+1){1'b0}};
    next_hi_s = {N{1'b0}};
    next_lo_s = {N{1'b0}};
    if (state_r == IDLE) begin
      load_s = start;
    end else begin
      load_s = 1'b0;
    end
    if (state_r == RUN) begin
      run_s  = 1'b1;
      last_s = (cnt_r == CW'(N - 1));
    end else begin
      run_s  = 1'b0;
      last_s = 1'b0;
    end
    if (p_lo_r[0]) begin
      sum_s = {1'b0, p_hi_r} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, p_hi_r};
    end
    next_hi_s = sum_s[N:1];
    next_lo_s = {sum_s[0], p_lo_r[N-1:1]};
  end

  // High half of the work register: cleared on accept, updated every RUN edge.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      p_hi_r <= {N{1'b0}};
    end else if (load_s) begin
      p_hi_r <= {N{1'b0}};
    end else if (run_s) begin
      p_hi_r <= next_hi_s;
    end else begin
      p_hi_r <= p_hi_r;
    end
  end

  // Low half of the work register: loaded with the multiplier on accept,
  // shifted every RUN edge.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      p_lo_r <= {N{1'b0}};
    end else if (load_s) begin
      p_lo_r <= mplier;
    end else if (run_s) begin
      p_lo_r <= next_lo_s;
    end else begin
      p_lo_r <= p_lo_r;
    end
  end

  // Control FSM with registered status outputs, the bit counter, the
  // multiplicand capture and the published product.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      mcand_r <= {N{1'b0}};
      product <= {(2*N){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            mcand_r <= mcand;
            cnt_r   <= {CW{1'b0}};
            ready   <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end else begin
            state_r <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        RUN: begin
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            // The final shift result goes straight to the product so that no
            // partial value is ever visible there.
            product <= {next_hi_s, next_lo_s};
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r <= RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
          ready <= 1'b0;
        end
        DONE: begin
          // start is deliberately ignored here; a new accept needs IDLE.
          state_r <= IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: randomized and directed checks of mult_seq_ctrl against
// a cycle-level behavioural model (operation age + arithmetic product).
module tb_mult_seq_ctrl;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           clear;
  logic           start;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: an operation is just "accepted at cycle acc with
  // operands a,b"; outputs follow from its age in cycles.
  int             cyc       = 0;
  bit             m_active  = 1'b0;
  int             m_acc     = 0;
  int             m_accepts = 0;
  logic [N-1:0]   m_a       = '0;
  logic [N-1:0]   m_b       = '0;
  logic [2*N-1:0] m_prod    = '0;
  int             dut_dones = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.N(N)) dut (
    .clk     (clk),
    .clear   (clear),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model update on each clock edge or on clear.
  always @(posedge clk or posedge clear) begin
    if (clear) begin
      m_active = 1'b0;
      m_prod   = '0;
    end else begin
      cyc++;
      if (m_active) begin
        if (cyc - m_acc == N) m_prod = (2*N)'(m_a) * (2*N)'(m_b);
        if (cyc - m_acc == N + 1) m_active = 1'b0;
      end else if (start) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_a      = mcand;
        m_b      = mplier;
        m_accepts++;
      end
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    int  k;
    bit  e_ready;
    bit  e_busy;
    bit  e_done;
    if (!clear) begin
      k       = cyc - m_acc;
      e_ready = !m_active;
      e_busy  = m_active && (k < N);
      e_done  = m_active && (k == N);
      chk("model_ready",   32'(ready),   32'(e_ready));
      chk("model_busy",    32'(busy),    32'(e_busy));
      chk("model_done",    32'(done),    32'(e_done));
      chk("model_product", 32'(product), 32'(m_prod));
      if (done) dut_dones++;
    end
  end

  task automatic drive(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    #1;
    start  = s;
    mcand  = a;
    mplier = b;
  endtask

  // One operation with a hand-computed product and the fixed latency.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [15:0] exp_p, input string name);
    int lat;
    bit seen;
    drive(1'b1, a, b);
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = N'($urandom);
    mplier = N'($urandom);
    seen   = 1'b0;
    lat    = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = i - 1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"},   32'(lat),  32'd8);
    chk({name, "_product"},   32'(product), 32'(exp_p));
    @(negedge clk);
    chk({name, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int base;
    int dones0;
    bit exited;
    clear  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #1;
    chk("reset_ready",   32'(ready),   32'd1);
    chk("reset_busy",    32'(busy),    32'd0);
    chk("reset_done",    32'(done),    32'd0);
    chk("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    clear = 1'b0;

    run_op(8'd13,  8'd11,  16'h008F, "m13x11");
    run_op(8'd255, 8'd255, 16'hFE01, "m255x255");
    run_op(8'd0,   8'd200, 16'h0000, "m0x200");
    run_op(8'd200, 8'd0,   16'h0000, "m200x0");

    // start during RUN and during DONE must be ignored.
    dones0 = dut_dones;
    drive(1'b1, 8'd6, 8'd7);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    start = 1'b1; mcand = 8'd9; mplier = 8'd9;
    @(negedge clk);
    #1;
    start = 1'b0;
    exited = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        exited = 1'b1;
        break;
      end
    end
    chk("ign_done_seen", 32'(exited), 32'd1);
    #1;
    start = 1'b1; mcand = 8'd9; mplier = 8'd9;
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("ign_ready", 32'(ready), 32'd1);
    chk("ign_busy",  32'(busy),  32'd0);
    repeat (12) @(negedge clk);
    chk("ign_one_done", 32'(dut_dones - dones0), 32'd1);
    chk("ign_product",  32'(product), 32'd42);

    // Asynchronous clear in the middle of RUN aborts the operation.
    dones0 = dut_dones;
    drive(1'b1, 8'd100, 8'd50);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    clear = 1'b1;
    #1;
    chk("clr_ready",   32'(ready),   32'd1);
    chk("clr_busy",    32'(busy),    32'd0);
    chk("clr_done",    32'(done),    32'd0);
    chk("clr_product", 32'(product), 32'd0);
    @(negedge clk);
    #1;
    clear = 1'b0;
    repeat (12) @(negedge clk);
    chk("clr_no_done", 32'(dut_dones - dones0), 32'd0);
    run_op(8'd3, 8'd5, 16'd15, "m3x5");

    // start held high across three operations, operands churning each cycle.
    base   = m_accepts;
    dones0 = dut_dones;
    exited = 1'b0;
    @(negedge clk);
    #1;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      mcand  = N'($urandom);
      mplier = N'($urandom);
      if (m_accepts >= base + 3) begin
        start  = 1'b0;
        exited = 1'b1;
        break;
      end
    end
    chk("b2b_three_accepts", 32'(exited), 32'd1);
    repeat (12) @(negedge clk);
    chk("b2b_three_dones", 32'(dut_dones - dones0), 32'd3);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (clear) begin
        clear = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        clear = 1'b1;
      end
      start  = ($urandom_range(0, 3) == 0);
      mcand  = N'($urandom);
      mplier = N'($urandom);
    end
    #1;
    clear = 1'b0;
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
